gearbox_132_lock_ctrl: RTL and testbench

- Block-lock controller for the 128b/132b gearbox output path, in the PHY write clock domain, between gearbox_128_132 and the 132-bit async FIFO write port.
- Checks the 4-bit sync header of every valid 132-bit block and acquires block lock.
- Sequences the gearbox with single-cycle slip pulses until alignment is found.
- While locked, forwards the 128-bit payload with a data/control flag and monitors the header error rate.

---
 rtl/gearbox_132_lock_ctrl.sv | 157 +++++++++++++++
 tb/tb_gearbox_132_lock_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_132_lock_ctrl.sv
// Block-lock controller for the 128b/132b gearbox: hunts for sync-header alignment with slip pulses,
// then forwards payload and drops lock on excessive header errors. All outputs registered, 1-cycle latency.
module gearbox_132_lock_ctrl #(
  parameter int          LOCK_CNT  = 64,
  parameter int          ERR_WIN   = 1024,
  parameter int          ERR_MAX   = 16,
  parameter int          SLIP_WAIT = 4,
  parameter logic [3:0]  HDR_DATA  = 4'b0011,
  parameter logic [3:0]  HDR_CTRL  = 4'b1100
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [131:0]   i_din,
  input  logic           i_din_valid,
  input  logic           i_err_clr,
  output logic           o_slip,
  output logic [127:0]   o_dout,
  output logic           o_dout_ctrl,
  output logic           o_dout_valid,
  output logic           o_block_lock,
  output logic           o_hdr_err,
  output logic [15:0]    o_err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WIN + 1);
  localparam int BW = $clog2(ERR_MAX + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {S_HUNT, S_SLIP, S_LOCKED} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   good_cnt, good_n;
  logic [WW-1:0]   win_cnt, win_n;
  logic [BW-1:0]   bad_cnt, bad_n;
  logic [SW-1:0]   slip_cnt, slip_cnt_n;
  logic            slip_n, hdr_err_n, dvld_n, ctrl_n;
  logic [127:0]    dout_n;
  logic [15:0]     err_cnt_n;

  logic [3:0] hdr;
  logic       hdr_ok;
  logic       win_wrap;

  assign hdr      = i_din[131:128];
  assign hdr_ok   = (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  assign win_wrap = (win_cnt == WW'(ERR_WIN - 1));

  always_comb begin
    state_n    = state;
    good_n     = good_cnt;
    win_n      = win_cnt;
    bad_n      = bad_cnt;
    slip_cnt_n = slip_cnt;
    slip_n     = 1'b0;
    hdr_err_n  = 1'b0;
    dvld_n     = 1'b0;
    err_cnt_n  = o_err_cnt;
    dout_n     = o_dout;
    ctrl_n     = o_dout_ctrl;

    if (i_din_valid) begin
      dout_n = i_din[127:0];
      ctrl_n = (hdr == HDR_CTRL);
      dvld_n = (state == S_LOCKED) && hdr_ok;

      case (state)
        S_HUNT: begin
          if (hdr_ok) begin
            if (good_cnt == GW'(LOCK_CNT - 1)) begin
              state_n = S_LOCKED;
              good_n  = '0;
              win_n   = '0;
              bad_n   = '0;
            end else begin
              good_n = good_cnt + GW'(1);
            end
          end else begin
            good_n     = '0;
            slip_n     = 1'b1;
            slip_cnt_n = '0;
            state_n    = S_SLIP;
          end
        end

        // Gearbox is still realigning; headers here are meaningless.
        S_SLIP: begin
          if (slip_cnt == SW'(SLIP_WAIT - 1)) begin
            slip_cnt_n = '0;
            state_n    = S_HUNT;
          end else begin
            slip_cnt_n = slip_cnt + SW'(1);
          end
        end

        S_LOCKED: begin
          win_n = win_wrap ? '0 : win_cnt + WW'(1);
          if (!hdr_ok) begin
            hdr_err_n = 1'b1;
            if (o_err_cnt != 16'hFFFF)
              err_cnt_n = o_err_cnt + 16'd1;
            // Loss of lock is checked before the window reset so a bad last block still counts.
            if (bad_cnt == BW'(ERR_MAX - 1)) begin
              slip_n     = 1'b1;
              slip_cnt_n = '0;
              state_n    = S_SLIP;
              bad_n      = '0;
              win_n      = '0;
            end else if (win_wrap) begin
              bad_n = '0;
            end else begin
              bad_n = bad_cnt + BW'(1);
            end
          end else if (win_wrap) begin
            bad_n = '0;
          end
        end

        default: state_n = S_HUNT;
      endcase
    end

    if (i_err_clr)
      err_cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_HUNT;
      good_cnt     <= '0;
      win_cnt      <= '0;
      bad_cnt      <= '0;
      slip_cnt     <= '0;
      o_slip       <= 1'b0;
      o_dout       <= '0;
      o_dout_ctrl  <= 1'b0;
      o_dout_valid <= 1'b0;
      o_hdr_err    <= 1'b0;
      o_err_cnt    <= '0;
    end else begin
      state        <= state_n;
      good_cnt     <= good_n;
      win_cnt      <= win_n;
      bad_cnt      <= bad_n;
      slip_cnt     <= slip_cnt_n;
      o_slip       <= slip_n;
      o_dout       <= dout_n;
      o_dout_ctrl  <= ctrl_n;
      o_dout_valid <= dvld_n;
      o_hdr_err    <= hdr_err_n;
      o_err_cnt    <= err_cnt_n;
    end
  end

  assign o_block_lock = (state == S_LOCKED);

endmodule

// File: tb/tb_gearbox_132_lock_ctrl.sv
// Directed testbench for gearbox_132_lock_ctrl with default parameters.
module tb_gearbox_132_lock_ctrl;

  localparam logic [3:0] HD = 4'b0011;
  localparam logic [3:0] HC = 4'b1100;
  localparam logic [3:0] HB = 4'b0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [131:0] i_din;
  logic         i_din_valid;
  logic         i_err_clr;
  logic         o_slip;
  logic [127:0] o_dout;
  logic         o_dout_ctrl;
  logic         o_dout_valid;
  logic         o_block_lock;
  logic         o_hdr_err;
  logic [15:0]  o_err_cnt;

  int total = 0;
  int bad   = 0;

  gearbox_132_lock_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .i_err_clr    (i_err_clr),
    .o_slip       (o_slip),
    .o_dout       (o_dout),
    .o_dout_ctrl  (o_dout_ctrl),
    .o_dout_valid (o_dout_valid),
    .o_block_lock (o_block_lock),
    .o_hdr_err    (o_hdr_err),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blk(input logic [3:0] h, input logic [127:0] p);
    i_din       = {h, p};
    i_din_valid = 1'b1;
    step();
  endtask

  task automatic idle();
    i_din_valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_din_valid = 1'b0;
    i_err_clr   = 1'b0;
    i_din       = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic lock_up();
    do_reset();
    for (int i = 0; i < 64; i++) blk(HD, 128'(i));
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_err_clr   = 1'b0;
    i_din       = {HB, {32{4'hF}}};
    i_din_valid = 1'b1;
    step();
    total++;
    if ({o_slip, o_dout, o_dout_ctrl, o_dout_valid, o_block_lock, o_hdr_err, o_err_cnt} !== '0) begin
      bad++; $display("FAIL reset_bad_hdr got lock=%b slip=%b dvld=%b err=%0d", o_block_lock, o_slip, o_dout_valid, o_err_cnt);
    end
    i_din = {HC, {32{4'hA}}};
    step();
    total++;
    if ({o_slip, o_dout, o_dout_ctrl, o_dout_valid, o_block_lock, o_hdr_err, o_err_cnt} !== '0) begin
      bad++; $display("FAIL reset_good_hdr got dout=%h ctrl=%b dvld=%b", o_dout, o_dout_ctrl, o_dout_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    bit ok = 1;
    do_reset();
    for (int i = 0; i < 63; i++) begin
      blk(HD, 128'(i));
      if (o_block_lock !== 1'b0 || o_dout_valid !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL lock_early got early lock or dout_valid, required none"); end
    blk(HD, 128'h64);
    total++;
    if (o_block_lock !== 1'b1) begin bad++; $display("FAIL lock_rise got=%b exp=1", o_block_lock); end
    total++;
    if (o_dout_valid !== 1'b0) begin bad++; $display("FAIL lock_blk_fwd got=%b exp=0", o_dout_valid); end
    blk(HD, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    total++;
    if (o_dout_valid !== 1'b1 || o_dout !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 || o_dout_ctrl !== 1'b0) begin
      bad++; $display("FAIL first_data got vld=%b dout=%h ctrl=%b", o_dout_valid, o_dout, o_dout_ctrl);
    end
    blk(HC, 128'hCAFE);
    total++;
    if (o_dout_valid !== 1'b1 || o_dout_ctrl !== 1'b1 || o_dout !== 128'hCAFE) begin
      bad++; $display("FAIL ctrl_blk got vld=%b ctrl=%b dout=%h exp 1 1 cafe", o_dout_valid, o_dout_ctrl, o_dout);
    end
    idle();
    total++;
    if (o_dout_valid !== 1'b0 || o_block_lock !== 1'b1) begin
      bad++; $display("FAIL idle_locked got vld=%b lock=%b exp 0 1", o_dout_valid, o_block_lock);
    end
  endtask

  task automatic test_slip();
    bit ok = 1;
    do_reset();
    for (int i = 0; i < 10; i++) blk(HD, 128'(i));
    blk(HB, 128'h0);
    total++;
    if (o_slip !== 1'b1 || o_block_lock !== 1'b0) begin bad++; $display("FAIL slip_pulse got slip=%b lock=%b exp 1 0", o_slip, o_block_lock); end
    for (int i = 0; i < 4; i++) begin
      blk(4'hF, 128'(i));
      if (o_slip !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL slip_wait_ignore got a slip during wait, required none"); end
    ok = 1;
    for (int i = 0; i < 63; i++) begin
      blk(HD, 128'(i));
      if (o_block_lock !== 1'b0 || o_slip !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL relock_early got lock/slip before 64 good blocks"); end
    blk(HD, 128'h1);
    total++;
    if (o_block_lock !== 1'b1) begin bad++; $display("FAIL relock got=%b exp=1", o_block_lock); end
  endtask

  task automatic test_err_window();
    bit ok = 1;
    int nerr = 0;
    lock_up();
    for (int i = 0; i < 1024; i++) begin
      blk((i % 64 == 5 && i < 960) ? HB : HD, 128'(i));
      if (o_hdr_err === 1'b1) nerr++;
      if (o_block_lock !== 1'b1 || o_slip !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL win1_hold got lock lost in first window"); end
    total++;
    if (nerr != 15) begin bad++; $display("FAIL win1_pulses got=%0d exp=15", nerr); end
    total++;
    if (o_err_cnt !== 16'd15) begin bad++; $display("FAIL win1_cnt got=%0d exp=15", o_err_cnt); end
    ok = 1;
    for (int i = 0; i < 483; i++) begin
      blk((i % 32 == 3) ? HB : HD, 128'(i));
      if (o_block_lock !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL win2_hold got lock lost before 16th error"); end
    blk(HB, 128'h0);
    total++;
    if (o_slip !== 1'b1 || o_block_lock !== 1'b0) begin bad++; $display("FAIL win2_loss got slip=%b lock=%b exp 1 0", o_slip, o_block_lock); end
    total++;
    if (o_err_cnt !== 16'd31) begin bad++; $display("FAIL win2_cnt got=%0d exp=31", o_err_cnt); end
  endtask

  task automatic test_loss_priority();
    bit ok = 1;
    lock_up();
    for (int i = 0; i < 1023; i++) begin
      blk((i % 64 == 5 && i < 960) ? HB : HD, 128'(i));
      if (o_block_lock !== 1'b1) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL prio_hold got lock lost early"); end
    blk(HB, 128'h0);
    total++;
    if (o_block_lock !== 1'b0 || o_slip !== 1'b1) begin bad++; $display("FAIL prio_loss got lock=%b slip=%b exp 0 1", o_block_lock, o_slip); end
    total++;
    if (o_err_cnt !== 16'd16 || o_dout_valid !== 1'b0) begin bad++; $display("FAIL prio_cnt got cnt=%0d vld=%b exp 16 0", o_err_cnt, o_dout_valid); end
  endtask

  task automatic test_valid_toggle();
    bit ok = 1;
    do_reset();
    for (int i = 0; i < 63; i++) begin
      blk(HD, 128'(i));
      if (o_dout_valid !== 1'b0) ok = 0;
      i_din = '0;
      idle();
      if (o_dout_valid !== 1'b0 || o_slip !== 1'b0) ok = 0;
    end
    total++;
    if (!ok || o_block_lock !== 1'b0) begin bad++; $display("FAIL toggle_hunt got lock=%b ok=%b exp 0 1", o_block_lock, ok); end
    blk(HD, 128'h40);
    total++;
    if (o_block_lock !== 1'b1) begin bad++; $display("FAIL toggle_lock got=%b exp=1", o_block_lock); end
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      blk(HD, 128'(i + 100));
      if (o_dout_valid !== 1'b1 || o_dout !== 128'(i + 100)) ok = 0;
      idle();
      if (o_dout_valid !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL toggle_fwd got dout_valid not following valid input"); end
  endtask

  task automatic test_reset_mid();
    lock_up();
    blk(HB, 128'h0);
    total++;
    if (o_hdr_err !== 1'b1 || o_err_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre got err=%b cnt=%0d exp 1 1", o_hdr_err, o_err_cnt); end
    rst_n = 1'b0;
    blk(HB, 128'h0);
    total++;
    if ({o_slip, o_dout_valid, o_block_lock, o_hdr_err, o_err_cnt} !== '0) begin
      bad++; $display("FAIL mid_reset got lock=%b err=%b slip=%b cnt=%0d exp all 0", o_block_lock, o_hdr_err, o_slip, o_err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_err_clr();
    lock_up();
    blk(HB, 128'h0);
    blk(HB, 128'h0);
    total++;
    if (o_err_cnt !== 16'd2) begin bad++; $display("FAIL clr_pre got=%0d exp=2", o_err_cnt); end
    i_err_clr = 1'b1;
    blk(HB, 128'h0);
    i_err_clr = 1'b0;
    total++;
    if (o_err_cnt !== 16'd0 || o_hdr_err !== 1'b1) begin bad++; $display("FAIL clr_wins got cnt=%0d err=%b exp 0 1", o_err_cnt, o_hdr_err); end
    blk(HB, 128'h0);
    total++;
    if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL clr_after got=%0d exp=1", o_err_cnt); end
  endtask

  initial begin
    rst_n       = 1'b0;
    i_din       = '0;
    i_din_valid = 1'b0;
    i_err_clr   = 1'b0;
    test_reset();
    test_lock();
    test_slip();
    test_err_window();
    test_loss_priority();
    test_valid_toggle();
    test_reset_mid();
    test_err_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
